// File: rtl/reduce_pkg.sv
// Shared flit layout and op-class constants for the reduction ingress path.
// Destination coordinates are packed Z:Y:X from high to low, so dst[n-1:0] starts at DstXPos.
package reduce_pkg;

    localparam int FlitWidth     = 82;
    localparam int ValidBitPos   = 81;
    localparam int PayloadWidth  = 32;
    localparam int PayloadPos    = 0;
    localparam int opPos         = 32;
    localparam int opWidth       = 4;
    localparam int DstFieldWidth = 3;
    localparam int DstXPos       = 36;
    localparam int DstYPos       = DstXPos + DstFieldWidth;
    localparam int DstZPos       = DstYPos + DstFieldWidth;

    localparam logic [1:0] OpClassReduce = 2'b11;

    function automatic logic is_reduce_op(input logic [opWidth-1:0] op);
        return op[opWidth-1 -: 2] == OpClassReduce;
    endfunction

endpackage

// File: rtl/reduce_fifo.sv
// First-word-fall-through FIFO with extended-pointer full/empty detection.
// The head entry is read combinationally so it is visible right after the pushing edge.
module reduce_fifo #(
    parameter int Width      = 85,
    parameter int LgDepth    = 4,
    parameter int CountWidth = 13
) (
    input  logic                  clk,
    input  logic                  rst_ni,
    input  logic                  push_i,
    input  logic [Width-1:0]      din_i,
    input  logic                  pop_i,
    output logic [Width-1:0]      dout_o,
    output logic [CountWidth-1:0] count_o,
    output logic                  full_o,
    output logic                  empty_o
);

    localparam int Depth = 2 ** LgDepth;

    logic [Width-1:0]   mem [Depth];
    logic [LgDepth:0]   wr_ptr_q, wr_ptr_d;
    logic [LgDepth:0]   rd_ptr_q, rd_ptr_d;
    logic [LgDepth:0]   occupancy;
    logic               do_push, do_pop;

    assign empty_o = (wr_ptr_q == rd_ptr_q);
    assign full_o  = (wr_ptr_q[LgDepth] != rd_ptr_q[LgDepth]) &&
                     (wr_ptr_q[LgDepth-1:0] == rd_ptr_q[LgDepth-1:0]);

    assign do_push = push_i && !full_o;
    assign do_pop  = pop_i && !empty_o;

    assign wr_ptr_d = do_push ? wr_ptr_q + 1'b1 : wr_ptr_q;
    assign rd_ptr_d = do_pop  ? rd_ptr_q + 1'b1 : rd_ptr_q;

    // Pointer difference wraps naturally, giving 0..Depth.
    assign occupancy = wr_ptr_q - rd_ptr_q;
    assign count_o   = {{(CountWidth-LgDepth-1){1'b0}}, occupancy};
    assign dout_o    = mem[rd_ptr_q[LgDepth-1:0]];

    always_ff @(posedge clk or negedge rst_ni) begin
        if (!rst_ni) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
        end
    end

    always_ff @(posedge clk) begin
        if (do_push) begin
            mem[wr_ptr_q[LgDepth-1:0]] <= din_i;
        end
    end

endmodule

// File: rtl/reduce_ingress.sv
// Router ingress for the reduction unit: steers reduction flits (tagged with their children
// mask) into a FWFT FIFO and everything else into a one-entry bypass register.
module reduce_ingress
    import reduce_pkg::*;
#(
    parameter logic [2:0] rank_z      = 3'b0,
    parameter logic [2:0] rank_y      = 3'b0,
    parameter logic [2:0] rank_x      = 3'b0,
    parameter int         lg_numprocs = 3,
    parameter int         lg_depth    = 4
) (
    input  logic                            clk,
    input  logic                            rst,
    input  logic [FlitWidth-1:0]            in_flit,
    input  logic                            in_valid,
    output logic                            in_ready,
    input  logic                            cfg_we,
    input  logic [lg_numprocs-1:0]          cfg_addr,
    input  logic [lg_numprocs-1:0]          cfg_children,
    output logic [FlitWidth+lg_numprocs-1:0] packetA,
    input  logic                            rd_en,
    output logic [12:0]                     fifo_counter,
    output logic                            buf_empty,
    output logic                            buf_full,
    output logic [FlitWidth-1:0]            bypass_flit,
    output logic                            bypass_valid,
    input  logic                            bypass_ready
);

    localparam int NumEntries = 2 ** lg_numprocs;
    localparam int EntryWidth = FlitWidth + lg_numprocs;

    logic [lg_numprocs-1:0] children_q [NumEntries];
    logic [lg_numprocs-1:0] child_idx;
    logic                   flit_is_red, flit_is_byp;
    logic                   accept, red_accept, byp_accept;
    logic [EntryWidth-1:0]  fifo_head;
    logic                   bypass_valid_q, bypass_valid_d;
    logic [FlitWidth-1:0]   bypass_flit_q, bypass_flit_d;

    assign child_idx   = in_flit[DstXPos +: lg_numprocs];
    assign flit_is_red = in_flit[ValidBitPos] && is_reduce_op(in_flit[opPos +: opWidth]);
    assign flit_is_byp = in_flit[ValidBitPos] && !flit_is_red;

    always_comb begin
        in_ready = 1'b1;
        if (flit_is_red) begin
            in_ready = !buf_full;
        end else if (flit_is_byp) begin
            in_ready = !bypass_valid_q || bypass_ready;
        end
        in_ready = in_ready && rst;
    end

    assign accept     = in_valid && in_ready;
    assign red_accept = accept && flit_is_red;
    assign byp_accept = accept && flit_is_byp;

    // Table reads see the old entry during a same-index write.
    generate
        for (genvar gi = 0; gi < NumEntries; gi++) begin : g_children
            always_ff @(posedge clk or negedge rst) begin
                if (!rst) begin
                    children_q[gi] <= '0;
                end else if (cfg_we && cfg_addr == lg_numprocs'(gi)) begin
                    children_q[gi] <= cfg_children;
                end
            end
        end
    endgenerate

    reduce_fifo #(
        .Width      (EntryWidth),
        .LgDepth    (lg_depth),
        .CountWidth (13)
    ) u_fifo (
        .clk     (clk),
        .rst_ni  (rst),
        .push_i  (red_accept),
        .din_i   ({children_q[child_idx], in_flit}),
        .pop_i   (rd_en),
        .dout_o  (fifo_head),
        .count_o (fifo_counter),
        .full_o  (buf_full),
        .empty_o (buf_empty)
    );

    assign packetA = {fifo_head[EntryWidth-1:ValidBitPos+1],
                      fifo_head[ValidBitPos] & ~buf_empty,
                      fifo_head[ValidBitPos-1:0]};

    always_comb begin
        bypass_valid_d = bypass_valid_q;
        bypass_flit_d  = bypass_flit_q;
        if (byp_accept) begin
            bypass_valid_d = 1'b1;
            bypass_flit_d  = in_flit;
        end else if (bypass_ready) begin
            bypass_valid_d = 1'b0;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            bypass_valid_q <= 1'b0;
            bypass_flit_q  <= '0;
        end else begin
            bypass_valid_q <= bypass_valid_d;
            bypass_flit_q  <= bypass_flit_d;
        end
    end

    assign bypass_valid = bypass_valid_q;
    assign bypass_flit  = bypass_flit_q;

endmodule
